playfield_pixel_fetch: RTL and testbench
========================================

// Module: playfield_pixel_fetch
// PURPOSE
// Upstream feeder of the VGA colour mapper. Holds the 10x20 Tetris board as 3-bit block_color cells.
// Overlays the falling piece on the board. For each scanned pixel it produces play_area, score_area
// and block_type, with DrawX/DrawY delayed to match, so the mapper colours the pixel directly.
// Owns board clearing at reset and at new game.
// PARAMETERS
// X0        240  left pixel column of play area
// Y0        80   top pixel row of play area
// COLS      10   board width in cells
// ROWS      20   board height in cells
// CSH       4    log2 cell size; cell is 16x16 px, so play area is 160x320 px
// SCORE_X0  10   score glyph left column; glyph is 8 px wide
// SCORE_Y0  10   score glyph top row; glyph is 16 px tall
// PORTS
// Clk           in   1   pixel clock
// Reset_n       in   1   asynchronous, active-low reset
// pix_valid     in   1   DrawX/DrawY valid this cycle
// DrawX, DrawY  in   10  current pixel coordinate
// frame_start   in   1   one-cycle pulse at start of vertical blank
// clear_req     in   1   one-cycle pulse: clear board (new game)
// wr_en         in   1   board cell write strobe
// wr_col        in   4   cell column, 0..COLS-1
// wr_row        in   5   cell row, 0..ROWS-1
// wr_color      in   3   block_color value to store
// piece_cells   in   36  4 x {col[3:0], row[4:0]}; cell i occupies bits [9i+8:9i]
// piece_color   in   3   block_color of the falling piece
// piece_vis     in   1   falling piece is drawn
// busy          out  1   clear sequence in progress
// out_valid     out  1   pix_valid delayed 2
// play_area     out  1   pixel lies inside the board
// score_area    out  1   pixel lies inside the score glyph box
// block_type    out  3   block_color for the pixel; EMPTY outside play_area
// DrawX_o, DrawY_o out 10 DrawX/DrawY delayed 2
// BEHAVIOUR
// - Reset (async, Reset_n=0): all outputs 0; block_type=EMPTY; FSM enters CLEAR with clr_addr=0;
//   piece shadow regs cleared, so shadow piece_vis=0.
// - Board RAM: COLS*ROWS x 3 bits, addr = row*10 + col (8 bits); synchronous read.
//   A same-cycle read and write of one address returns the OLD value.
// - FSM CLEAR: each cycle writes EMPTY to clr_addr, then increments clr_addr.
//   After writing addr 199 it goes to RUN; CLEAR lasts exactly 200 cycles; busy=1 throughout.
// - FSM RUN: wr_en with col<COLS and row<ROWS writes wr_color. An out-of-range write is dropped.
//   clear_req goes to CLEAR at addr 0.
// - clear_req during CLEAR restarts at addr 0. wr_en during CLEAR is ignored.
//   During CLEAR, block_type is forced to EMPTY.
// - Piece shadow: piece_cells, piece_color and piece_vis are latched on frame_start only,
//   so there is no mid-frame tearing. Pixels entering stage 1 on the cycle after frame_start
//   use the new shadow.
// - Stage 1 (registered):
//   - pa = X0<=DrawX<X0+160 && Y0<=DrawY<Y0+320
//   - sa = SCORE_X0<=DrawX<SCORE_X0+8 && SCORE_Y0<=DrawY<SCORE_Y0+16
//   - col=(DrawX-X0)>>CSH, row=(DrawY-Y0)>>CSH; issue RAM read
//   - hit = piece_vis && any shadow cell == {col,row}
// - Stage 2 (registered outputs):
//   - block_type = !pa ? EMPTY : hit ? piece_color : ram_q
//   - play_area=pa, score_area=sa; pa and sa are never both 1
// - Latency: exactly 2 cycles from DrawX/DrawY/pix_valid to all outputs, every cycle, no stalls.
//   When pix_valid=0, outputs still advance and out_valid=0.
// - Piece cells with col>=COLS or row>=ROWS never match.
//   Overlapping piece cells are harmless.
// - Widths: subtraction is 10-bit unsigned; pa is gated before col/row are used,
//   so underflow is ignored.
// TESTING
// 1 Reset release -> busy=1 for 200 cycles then 0; every cell reads EMPTY; writes during busy lost.
// 2 RUN write (col3,row5,RED); scan DrawX=240+3*16+7, DrawY=80+5*16 -> 2 cycles later play_area=1, block_type=RED.
// 3 Scan (239,80),(400,80),(240,400) -> play_area=0, block_type=EMPTY; (10,10),(17,25) -> score_area=1; (18,10) -> 0.
// 4 Change piece to {0,0} CYAN mid-frame -> no change until frame_start; after it, pixel (240,80) -> CYAN over board.
// 5 Write + read same cell same cycle -> old value; next scan -> new value; write col=12 -> RAM unchanged.
// 6 clear_req at addr 100 of CLEAR -> restart, busy stays 1 for 200 more cycles; async reset mid-scan -> outputs 0 at once.

Source files
------------

// File: rtl/playfield_pixel_fetch.sv
`default_nettype none
// ============================================================================
//  Module   : playfield_pixel_fetch
//  Purpose  : Pixel-rate feeder for the VGA colour mapper. Holds the Tetris
//             board (COLS x ROWS cells of 3-bit block colour), overlays the
//             falling piece and, for every scanned pixel, emits play_area,
//             score_area and block_type together with the matching delayed
//             coordinates. Clears the board after reset and on new game.
//  Ports    : Clk, Reset_n (async, active-low)
//             pix_valid, DrawX, DrawY          scanned pixel in
//             frame_start                      latches piece shadow
//             clear_req                        restart board clear
//             wr_en, wr_col, wr_row, wr_color  board cell write
//             piece_cells, piece_color, piece_vis  falling piece
//             busy                             clear sequence running
//             out_valid, play_area, score_area, block_type,
//             DrawX_o, DrawY_o                 pixel out, 2 cycles later
//  Revision : 1.0  initial release
// ============================================================================
module playfield_pixel_fetch #(
    parameter int X0       = 240,
    parameter int Y0       = 80,
    parameter int COLS     = 10,
    parameter int ROWS     = 20,
    parameter int CSH      = 4,
    parameter int SCORE_X0 = 10,
    parameter int SCORE_Y0 = 10
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic        pix_valid,
    input  logic [9:0]  DrawX,
    input  logic [9:0]  DrawY,
    input  logic        frame_start,
    input  logic        clear_req,
    input  logic        wr_en,
    input  logic [3:0]  wr_col,
    input  logic [4:0]  wr_row,
    input  logic [2:0]  wr_color,
    input  logic [35:0] piece_cells,
    input  logic [2:0]  piece_color,
    input  logic        piece_vis,
    output logic        busy,
    output logic        out_valid,
    output logic        play_area,
    output logic        score_area,
    output logic [2:0]  block_type,
    output logic [9:0]  DrawX_o,
    output logic [9:0]  DrawY_o
);

    localparam int          CELLS     = COLS * ROWS;
    localparam logic [2:0]  EMPTY     = 3'd0;
    localparam logic [7:0]  LAST_ADDR = 8'(CELLS - 1);
    localparam logic [3:0]  COLS_L    = 4'(COLS);
    localparam logic [4:0]  ROWS_L    = 5'(ROWS);
    localparam logic [7:0]  COLS_A    = 8'(COLS);
    localparam logic [9:0]  X_LO      = 10'(X0);
    localparam logic [9:0]  X_HI      = 10'(X0 + (COLS << CSH));
    localparam logic [9:0]  Y_LO      = 10'(Y0);
    localparam logic [9:0]  Y_HI      = 10'(Y0 + (ROWS << CSH));
    localparam logic [9:0]  SX_LO     = 10'(SCORE_X0);
    localparam logic [9:0]  SX_HI     = 10'(SCORE_X0 + 8);
    localparam logic [9:0]  SY_LO     = 10'(SCORE_Y0);
    localparam logic [9:0]  SY_HI     = 10'(SCORE_Y0 + 16);

    typedef enum logic [0:0] {
        S_CLEAR = 1'b0,
        S_RUN   = 1'b1
    } state_e;

    state_e      state_q, state_d;
    logic [7:0]  clr_addr_q, clr_addr_d;

    logic        mem_we;
    logic [7:0]  mem_waddr;
    logic [2:0]  mem_wdata;

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q    <= S_CLEAR;
            clr_addr_q <= 8'd0;
        end else begin
            state_q    <= state_d;
            clr_addr_q <= clr_addr_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        clr_addr_d = clr_addr_q;
        mem_we     = 1'b0;
        mem_waddr  = 8'd0;
        mem_wdata  = EMPTY;
        case (state_q)
            S_CLEAR: begin
                // Host writes are ignored while the sweep owns the RAM port.
                mem_we    = 1'b1;
                mem_waddr = clr_addr_q;
                if (clear_req) begin
                    clr_addr_d = 8'd0;
                end else if (clr_addr_q == LAST_ADDR) begin
                    state_d    = S_RUN;
                    clr_addr_d = 8'd0;
                end else begin
                    clr_addr_d = clr_addr_q + 8'd1;
                end
            end
            S_RUN: begin
                // Out-of-range cells would alias onto other rows; drop them.
                if (wr_en && (wr_col < COLS_L) && (wr_row < ROWS_L)) begin
                    mem_we    = 1'b1;
                    mem_waddr = 8'(wr_row) * COLS_A + 8'(wr_col);
                    mem_wdata = wr_color;
                end
                if (clear_req) begin
                    state_d    = S_CLEAR;
                    clr_addr_d = 8'd0;
                end
            end
            default: begin
                state_d    = S_CLEAR;
                clr_addr_d = 8'd0;
            end
        endcase
    end

    assign busy = (state_q == S_CLEAR);

    // ------------------------------------------------------- piece shadow
    logic [35:0] sh_cells_q;
    logic [2:0]  sh_color_q;
    logic        sh_vis_q;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            sh_cells_q <= 36'd0;
            sh_color_q <= EMPTY;
            sh_vis_q   <= 1'b0;
        end else if (frame_start) begin
            sh_cells_q <= piece_cells;
            sh_color_q <= piece_color;
            sh_vis_q   <= piece_vis;
        end
    end

    // ------------------------------------------------- stage 1 decode
    logic [9:0] w_dx, w_dy;
    logic [3:0] w_col;
    logic [4:0] w_row;
    logic       w_pa, w_sa, w_hit;
    logic [7:0] w_raddr;

    // Wrapped differences outside the board are harmless: every consumer
    // below is qualified by w_pa.
    assign w_dx    = DrawX - X_LO;
    assign w_dy    = DrawY - Y_LO;
    assign w_col   = 4'(w_dx >> CSH);
    assign w_row   = 5'(w_dy >> CSH);
    assign w_pa    = (DrawX >= X_LO) && (DrawX < X_HI) &&
                     (DrawY >= Y_LO) && (DrawY < Y_HI);
    assign w_sa    = (DrawX >= SX_LO) && (DrawX < SX_HI) &&
                     (DrawY >= SY_LO) && (DrawY < SY_HI);
    assign w_raddr = w_pa ? (8'(w_row) * COLS_A + 8'(w_col)) : 8'd0;

    always_comb begin
        w_hit = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if ((sh_cells_q[9*i+5 +: 4] == w_col) &&
                (sh_cells_q[9*i   +: 5] == w_row) &&
                (sh_cells_q[9*i+5 +: 4] <  COLS_L) &&
                (sh_cells_q[9*i   +: 5] <  ROWS_L)) begin
                w_hit = 1'b1;
            end
        end
        w_hit = w_hit & sh_vis_q & w_pa;
    end

    // ------------------------------------------------------- board RAM
    // Read-before-write: a same-edge write to the read address yields the
    // previous contents.
    logic [2:0] mem [0:CELLS-1];
    logic [2:0] ram_q;

    always_ff @(posedge Clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
        ram_q <= mem[w_raddr];
    end

    // -------------------------------------------------- stage 1 regs
    logic       vld1_q, pa1_q, sa1_q, hit1_q;
    logic [2:0] hcol1_q;
    logic [9:0] x1_q, y1_q;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            vld1_q  <= 1'b0;
            pa1_q   <= 1'b0;
            sa1_q   <= 1'b0;
            hit1_q  <= 1'b0;
            hcol1_q <= EMPTY;
            x1_q    <= 10'd0;
            y1_q    <= 10'd0;
        end else begin
            vld1_q  <= pix_valid;
            pa1_q   <= w_pa;
            sa1_q   <= w_sa;
            hit1_q  <= w_hit;
            // Colour travels with the hit so a frame_start between the
            // two stages cannot recolour a pixel already in flight.
            hcol1_q <= sh_color_q;
            x1_q    <= DrawX;
            y1_q    <= DrawY;
        end
    end

    // -------------------------------------------------- stage 2 regs
    logic [2:0] bt_d;
    logic       vld2_q, pa2_q, sa2_q;
    logic [2:0] bt2_q;
    logic [9:0] x2_q, y2_q;

    always_comb begin
        bt_d = ram_q;
        if (busy || !pa1_q) begin
            bt_d = EMPTY;
        end else if (hit1_q) begin
            bt_d = hcol1_q;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            vld2_q <= 1'b0;
            pa2_q  <= 1'b0;
            sa2_q  <= 1'b0;
            bt2_q  <= EMPTY;
            x2_q   <= 10'd0;
            y2_q   <= 10'd0;
        end else begin
            vld2_q <= vld1_q;
            pa2_q  <= pa1_q;
            sa2_q  <= sa1_q;
            bt2_q  <= bt_d;
            x2_q   <= x1_q;
            y2_q   <= y1_q;
        end
    end

    assign out_valid  = vld2_q;
    assign play_area  = pa2_q;
    assign score_area = sa2_q;
    assign block_type = bt2_q;
    assign DrawX_o    = x2_q;
    assign DrawY_o    = y2_q;

endmodule
`default_nettype wire

// File: tb/tb_playfield_pixel_fetch.sv
`default_nettype none
// ============================================================================
//  Module   : tb_playfield_pixel_fetch
//  Purpose  : Randomised scoreboard bench for playfield_pixel_fetch. A board
//             model (2-D array plus piece shadow) predicts each pixel; a
//             monitor pops predictions whenever out_valid is seen.
//  Revision : 1.0  initial release
// ============================================================================
module tb_playfield_pixel_fetch;

    logic        Clk = 1'b0;
    logic        Reset_n;
    logic        pix_valid, frame_start, clear_req, wr_en, piece_vis;
    logic [9:0]  DrawX, DrawY;
    logic [3:0]  wr_col;
    logic [4:0]  wr_row;
    logic [2:0]  wr_color, piece_color;
    logic [35:0] piece_cells;
    logic        busy, out_valid, play_area, score_area;
    logic [2:0]  block_type;
    logic [9:0]  DrawX_o, DrawY_o;

    always #5 Clk = ~Clk;

    playfield_pixel_fetch dut (
        .Clk(Clk), .Reset_n(Reset_n), .pix_valid(pix_valid),
        .DrawX(DrawX), .DrawY(DrawY), .frame_start(frame_start),
        .clear_req(clear_req), .wr_en(wr_en), .wr_col(wr_col),
        .wr_row(wr_row), .wr_color(wr_color), .piece_cells(piece_cells),
        .piece_color(piece_color), .piece_vis(piece_vis), .busy(busy),
        .out_valid(out_valid), .play_area(play_area), .score_area(score_area),
        .block_type(block_type), .DrawX_o(DrawX_o), .DrawY_o(DrawY_o)
    );

    // ------------------------------------------------------------ model
    logic [2:0]  board [20][10];
    bit          known [20][10];
    bit          m_busy;
    int          m_clr;
    logic [35:0] m_cells;
    logic [2:0]  m_pcol;
    bit          m_vis;

    typedef struct {
        bit         pa;
        bit         sa;
        logic [2:0] bt;
        bit         dc;
        logic [9:0] x;
        logic [9:0] y;
    } exp_t;
    exp_t sb[$];

    int checks = 0;
    int errors = 0;

    task automatic model_reset();
        m_busy  = 1'b1;
        m_clr   = 0;
        m_cells = '0;
        m_pcol  = 3'd0;
        m_vis   = 1'b0;
        for (int r = 0; r < 20; r++)
            for (int c = 0; c < 10; c++) known[r][c] = 1'b0;
    endtask

    // One clock of stimulus: drive, predict, advance model, check busy.
    task automatic cyc(input bit pv, input int x, input int y, input bit fs,
                       input bit cr, input bit we, input int wc, input int wr,
                       input logic [2:0] wcolor);
        exp_t e;
        int   col, row;
        bit   hit;
        pix_valid   = pv;
        DrawX       = 10'(x);
        DrawY       = 10'(y);
        frame_start = fs;
        clear_req   = cr;
        wr_en       = we;
        wr_col      = 4'(wc);
        wr_row      = 5'(wr);
        wr_color    = wcolor;

        e.x  = 10'(x);
        e.y  = 10'(y);
        e.pa = (x >= 240) && (x < 400) && (y >= 80) && (y < 400);
        e.sa = (x >= 10) && (x < 18) && (y >= 10) && (y < 26);
        e.bt = 3'd0;
        e.dc = 1'b0;
        if (e.pa) begin
            col = (x - 240) / 16;
            row = (y - 80) / 16;
            hit = 1'b0;
            for (int i = 0; i < 4; i++) begin
                int pc, pr;
                pc = int'(m_cells[9*i+5 +: 4]);
                pr = int'(m_cells[9*i +: 5]);
                if (m_vis && pc < 10 && pr < 20 && pc == col && pr == row) hit = 1'b1;
            end
            if (hit) e.bt = m_pcol;
            else begin
                e.bt = board[row][col];
                e.dc = !known[row][col];
            end
        end

        if (fs) begin
            m_cells = piece_cells;
            m_pcol  = piece_color;
            m_vis   = piece_vis;
        end
        if (m_busy) begin
            board[m_clr / 10][m_clr % 10] = 3'd0;
            known[m_clr / 10][m_clr % 10] = 1'b1;
            if (cr) m_clr = 0;
            else if (m_clr == 199) begin
                m_busy = 1'b0;
                m_clr  = 0;
            end else m_clr++;
        end else begin
            if (we && wc < 10 && wr < 20) begin
                board[wr][wc] = wcolor;
                known[wr][wc] = 1'b1;
            end
            if (cr) begin
                m_busy = 1'b1;
                m_clr  = 0;
            end
        end
        // Output stage sees the clear state as it stands after this edge.
        if (m_busy) begin
            e.bt = 3'd0;
            e.dc = 1'b0;
        end
        if (pv) sb.push_back(e);

        @(posedge Clk);
        #1;
        checks++;
        if (busy !== m_busy) begin
            errors++;
            $display("FAIL busy t=%0t: got %0b expected %0b", $time, busy, m_busy);
        end
    endtask

    task automatic rand_pix(output int x, output int y);
        int r;
        r = int'($urandom_range(0, 9));
        if (r < 6) begin
            x = 240 + int'($urandom_range(0, 159));
            y = 80 + int'($urandom_range(0, 319));
        end else if (r < 8) begin
            x = int'($urandom_range(6, 20));
            y = int'($urandom_range(6, 28));
        end else begin
            x = int'($urandom_range(0, 1023));
            y = int'($urandom_range(0, 1023));
        end
    endtask

    task automatic rand_piece();
        for (int i = 0; i < 4; i++) begin
            piece_cells[9*i+5 +: 4] = 4'($urandom_range(0, 11));
            piece_cells[9*i +: 5]   = 5'($urandom_range(0, 21));
        end
        piece_color = 3'($urandom_range(1, 7));
        piece_vis   = ($urandom_range(0, 3) != 0);
    endtask

    task automatic rand_cyc(input bit allow_clear);
        int x, y;
        bit cr;
        rand_pix(x, y);
        if ($urandom_range(0, 19) == 0) rand_piece();
        cr = allow_clear && ($urandom_range(0, 699) == 0);
        cyc($urandom_range(0, 3) != 0, x, y, $urandom_range(0, 99) == 0, cr,
            $urandom_range(0, 2) == 0, int'($urandom_range(0, 11)),
            int'($urandom_range(0, 21)), 3'($urandom_range(0, 7)));
    endtask

    task automatic idle_cyc();
        cyc(1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 0, 0, 3'd0);
    endtask

    // ---------------------------------------------------------- monitor
    always @(negedge Clk) begin
        if (Reset_n === 1'b1 && out_valid === 1'b1) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_output x=%0d y=%0d: got out_valid=1 expected no pixel",
                         DrawX_o, DrawY_o);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (play_area !== e.pa || score_area !== e.sa || DrawX_o !== e.x ||
                    DrawY_o !== e.y || (!e.dc && block_type !== e.bt)) begin
                    errors++;
                    $display("FAIL pixel: got x=%0d y=%0d pa=%0b sa=%0b bt=%0d expected x=%0d y=%0d pa=%0b sa=%0b bt=%0d",
                             DrawX_o, DrawY_o, play_area, score_area, block_type,
                             e.x, e.y, e.pa, e.sa, e.bt);
                end
            end
        end
    end

    // -------------------------------------------------------- stimulus
    initial begin
        int guard;
        Reset_n     = 1'b0;
        pix_valid   = 1'b0;
        DrawX       = '0;
        DrawY       = '0;
        frame_start = 1'b0;
        clear_req   = 1'b0;
        wr_en       = 1'b0;
        wr_col      = '0;
        wr_row      = '0;
        wr_color    = '0;
        piece_cells = '0;
        piece_color = '0;
        piece_vis   = 1'b0;
        model_reset();
        repeat (3) @(posedge Clk);
        #1;
        checks++;
        if ({out_valid, play_area, score_area, block_type, DrawX_o, DrawY_o} !== '0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL reset_state: got ov=%0b pa=%0b sa=%0b bt=%0d busy=%0b expected all 0 busy=1",
                     out_valid, play_area, score_area, block_type, busy);
        end
        Reset_n = 1'b1;

        // Initial clear, with host writes that must be lost.
        repeat (205) rand_cyc(1'b0);
        for (int r = 0; r < 20; r++)
            for (int c = 0; c < 10; c++)
                cyc(1'b1, 240 + c * 16 + 5, 80 + r * 16 + 9, 1'b0, 1'b0, 1'b0, 0, 0, 3'd0);

        // Write and scan a cell, then the play/score boundaries.
        cyc(1'b0, 0, 0, 1'b0, 1'b0, 1'b1, 3, 5, 3'd4);
        cyc(1'b1, 240 + 3 * 16 + 7, 80 + 5 * 16, 1'b0, 1'b0, 1'b0, 0, 0, 3'd0);
        cyc(1'b1, 239, 80, 1'b0, 1'b0, 1'b0, 0, 0, 3'd0);
        cyc(1'b1, 400, 80, 1'b0, 1'b0, 1'b0, 0, 0, 3'd0);
        cyc(1'b1, 240, 400, 1'b0, 1'b0, 1'b0, 0, 0, 3'd0);
        cyc(1'b1, 10, 10, 1'b0, 1'b0, 1'b0, 0, 0, 3'd0);
        cyc(1'b1, 17, 25, 1'b0, 1'b0, 1'b0, 0, 0, 3'd0);
        cyc(1'b1, 18, 10, 1'b0, 1'b0, 1'b0, 0, 0, 3'd0);
        cyc(1'b1, 399, 399, 1'b0, 1'b0, 1'b0, 0, 0, 3'd0);

        // Piece shadow only follows frame_start.
        cyc(1'b0, 0, 0, 1'b0, 1'b0, 1'b1, 0, 0, 3'd2);
        piece_cells = {4'd15, 5'd31, 4'd10, 5'd0, 4'd0, 5'd20, 4'd0, 5'd0};
        piece_color = 3'd3;
        piece_vis   = 1'b1;
        cyc(1'b1, 240, 80, 1'b0, 1'b0, 1'b0, 0, 0, 3'd0);
        cyc(1'b1, 240, 80, 1'b1, 1'b0, 1'b0, 0, 0, 3'd0);
        cyc(1'b1, 240, 80, 1'b0, 1'b0, 1'b0, 0, 0, 3'd0);
        cyc(1'b1, 240, 80 + 16, 1'b0, 1'b0, 1'b0, 0, 0, 3'd0);

        // Read-during-write and dropped out-of-range writes.
        cyc(1'b1, 240 + 32 + 3, 80 + 32 + 3, 1'b0, 1'b0, 1'b1, 2, 2, 3'd5);
        cyc(1'b1, 240 + 32 + 3, 80 + 32 + 3, 1'b0, 1'b0, 1'b0, 0, 0, 3'd0);
        cyc(1'b0, 0, 0, 1'b0, 1'b0, 1'b1, 12, 0, 3'd7);
        cyc(1'b0, 0, 0, 1'b0, 1'b0, 1'b1, 3, 25, 3'd7);
        cyc(1'b1, 240 + 32 + 1, 80 + 16 + 1, 1'b0, 1'b0, 1'b0, 0, 0, 3'd0);
        cyc(1'b1, 240 + 48 + 1, 80 + 1, 1'b0, 1'b0, 1'b0, 0, 0, 3'd0);

        // Long randomised run.
        repeat (1500) rand_cyc(1'b1);

        // clear_req, then again at clear address 100.
        guard = 0;
        while (m_busy && guard < 400) begin
            idle_cyc();
            guard++;
        end
        cyc(1'b0, 0, 0, 1'b0, 1'b1, 1'b0, 0, 0, 3'd0);
        repeat (100) rand_cyc(1'b0);
        cyc(1'b0, 0, 0, 1'b0, 1'b1, 1'b0, 0, 0, 3'd0);
        repeat (205) rand_cyc(1'b0);
        repeat (200) rand_cyc(1'b0);

        // Asynchronous reset in the middle of a scan.
        repeat (3) cyc(1'b1, 300, 200, 1'b0, 1'b0, 1'b0, 0, 0, 3'd0);
        pix_valid = 1'b1;
        DrawX     = 10'd250;
        DrawY     = 10'd90;
        #2;
        Reset_n = 1'b0;
        #1;
        checks++;
        if ({out_valid, play_area, score_area, block_type, DrawX_o, DrawY_o} !== '0) begin
            errors++;
            $display("FAIL async_reset: got ov=%0b pa=%0b sa=%0b bt=%0d x=%0d y=%0d expected all 0",
                     out_valid, play_area, score_area, block_type, DrawX_o, DrawY_o);
        end
        sb.delete();
        model_reset();
        pix_valid = 1'b0;
        repeat (2) @(posedge Clk);
        #1;
        Reset_n = 1'b1;
        repeat (210) rand_cyc(1'b0);
        repeat (300) rand_cyc(1'b1);

        repeat (4) idle_cyc();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending pixels expected 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
